uart_ext: RTL and testbench

//  Parametrised full-duplex UART; successor to the fixed 8N1 uart block.

---
 rtl/uart_ext.sv | 365 ++++++++++++++++++++++++++++++++++++
 tb/tb_uart_ext.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ext.sv
// uart_ext: parametrised full-duplex UART, configurable width/parity/stop/oversampling; RX FIFO when UART_RX_FIFO_EN is defined.
// Latency: TX busy from the clk after start_transmit; RX word stored 1 clk after the mid-stop-bit sample.
// Backpressure: start_transmit ignored while busy; RX frames arriving with no free slot are dropped and flag overrun_error.

`ifdef UART_RX_FIFO_EN
// uart_ext_fifo: generic first-word-fall-through FIFO for the RX path.
// Latency: pushed word visible on pop_dat the clk after the push.
// Backpressure: push_rdy low only when full and no pop is taken in the same clk.
module uart_ext_fifo #(
    parameter int W          = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_vld,
    input  logic [W-1:0]          push_dat,
    output logic                  push_rdy,
    output logic                  pop_vld,
    output logic [W-1:0]          pop_dat,
    input  logic                  pop_rdy
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = DEPTH[DEPTH_LOG2:0];

    logic [W-1:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [DEPTH_LOG2:0]     count;
    logic                    do_push;
    logic                    do_pop;

    assign pop_vld  = (count != '0);
    assign pop_dat  = mem[rd_ptr];
    // A pop in the same clk frees the slot the push is about to use.
    assign push_rdy = (count != FULL_CNT) | pop_rdy;
    assign do_pop   = pop_rdy & pop_vld;
    assign do_push  = push_vld & push_rdy;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
`endif

// uart_ext: full-duplex UART with parity/framing/overrun flags.
// Latency: TX line follows start_transmit by 1 clk; RX store 1 clk after the stop sample.
// Backpressure: busy blocks new TX requests; RX overrun drops the incoming frame.
module uart_ext #(
    parameter int clock_frequency = 12000000,
    parameter int baud_rate       = 9600,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int OVERSAMPLE      = 16,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic                 start_transmit,
    input  logic [DATA_BITS-1:0] data_to_send,
    output logic                 busy,
    output logic [DATA_BITS-1:0] recvd_data,
    output logic                 new_value,
    input  logic                 clear,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 overrun_error
);
    localparam int DIV     = clock_frequency / (baud_rate * OVERSAMPLE);
    localparam int BIT_CLK = DIV * OVERSAMPLE;
    localparam int DCW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TCW     = $clog2(BIT_CLK);
    localparam int OCW     = $clog2(OVERSAMPLE);

    localparam logic [DCW-1:0] DIV_LAST  = DCW'(DIV - 1);
    localparam logic [TCW-1:0] BIT_LAST  = TCW'(BIT_CLK - 1);
    localparam logic [OCW-1:0] OS_LAST   = OCW'(OVERSAMPLE - 1);
    localparam logic [OCW-1:0] HALF_LAST = OCW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic           HAS_PAR   = (PARITY != 0);
    localparam logic           ODD       = (PARITY == 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2 || OVERSAMPLE < 8 ||
            (OVERSAMPLE % 2) != 0 || DIV < 1 || FIFO_DEPTH_LOG2 < 1) begin : g_bad_cfg
            $error("uart_ext: unsupported parameter set");
        end
    endgenerate

    // ---------------- sample tick ----------------
    logic [DCW-1:0] div_cnt;
    logic           sample_tick;

    assign sample_tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst || sample_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // ---------------- transmitter ----------------
    // TX times whole bit periods in clk so the frame length is exact from the request.
    logic [2:0]           tx_state;
    logic [TCW-1:0]       tx_cnt;
    logic [3:0]           tx_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;

    assign busy = (tx_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx       <= 1'b1;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
        end else if (tx_state == S_IDLE) begin
            if (start_transmit) begin
                tx_shift <= data_to_send;
                tx_par   <= (^data_to_send) ^ ODD;
                tx_state <= S_START;
                tx       <= 1'b0;
                tx_cnt   <= '0;
            end
        end else if (tx_cnt != BIT_LAST) begin
            tx_cnt <= tx_cnt + 1'b1;
        end else begin
            tx_cnt <= '0;
            case (tx_state)
                S_START: begin
                    tx_state <= S_DATA;
                    tx_idx   <= '0;
                    tx       <= tx_shift[0];
                end
                S_DATA: begin
                    if (tx_idx == DATA_LAST) begin
                        tx_idx   <= '0;
                        tx_state <= HAS_PAR ? S_PAR : S_STOP;
                        tx       <= HAS_PAR ? tx_par : 1'b1;
                    end else begin
                        tx_idx   <= tx_idx + 1'b1;
                        tx_shift <= tx_shift >> 1;
                        tx       <= tx_shift[1];
                    end
                end
                S_PAR: begin
                    tx_state <= S_STOP;
                    tx_idx   <= '0;
                    tx       <= 1'b1;
                end
                S_STOP: begin
                    tx <= 1'b1;
                    if (tx_idx == STOP_LAST) begin
                        tx_state <= S_IDLE;
                    end else begin
                        tx_idx <= tx_idx + 1'b1;
                    end
                end
                default: begin
                    tx_state <= S_IDLE;
                    tx       <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- receiver front end ----------------
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;
    logic rx_fall;

    assign rx_fall = rx_prev & ~rx_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // ---------------- receiver FSM ----------------
    logic [2:0]           rx_state;
    logic [OCW-1:0]       rx_cnt;
    logic [3:0]           rx_idx;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_bit;
    logic                 rx_store;
    logic                 rx_pe;
    logic                 rx_fe;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state   <= S_IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rx_par_bit <= 1'b0;
            rx_store   <= 1'b0;
            rx_pe      <= 1'b0;
            rx_fe      <= 1'b0;
        end else begin
            rx_store <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    if (rx_fall) begin
                        rx_state <= S_START;
                        rx_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (sample_tick) begin
                        if (rx_cnt == HALF_LAST) begin
                            // A start bit that is high again at mid-bit was only a glitch.
                            rx_state <= rx_sync ? S_IDLE : S_DATA;
                            rx_cnt   <= '0;
                            rx_idx   <= '0;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (sample_tick) begin
                        if (rx_cnt == OS_LAST) begin
                            rx_cnt   <= '0;
                            rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                            if (rx_idx == DATA_LAST) begin
                                rx_state <= HAS_PAR ? S_PAR : S_STOP;
                            end else begin
                                rx_idx <= rx_idx + 1'b1;
                            end
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end
                end
                S_PAR: begin
                    if (sample_tick) begin
                        if (rx_cnt == OS_LAST) begin
                            rx_cnt     <= '0;
                            rx_par_bit <= rx_sync;
                            rx_state   <= S_STOP;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (sample_tick) begin
                        if (rx_cnt == OS_LAST) begin
                            rx_cnt   <= '0;
                            rx_pe    <= HAS_PAR & ((^rx_shift) ^ rx_par_bit ^ ODD);
                            rx_fe    <= ~rx_sync;
                            rx_store <= 1'b1;
                            rx_state <= S_IDLE;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- frame store ----------------
    logic store_ok;
    logic store_drop;

`ifdef UART_RX_FIFO_EN
    logic                 fifo_push_rdy;
    logic                 fifo_vld;
    logic [DATA_BITS-1:0] fifo_dat;

    uart_ext_fifo #(
        .W          (DATA_BITS),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (rx_store),
        .push_dat (rx_shift),
        .push_rdy (fifo_push_rdy),
        .pop_vld  (fifo_vld),
        .pop_dat  (fifo_dat),
        .pop_rdy  (clear)
    );

    assign store_ok   = rx_store & fifo_push_rdy;
    assign store_drop = rx_store & ~fifo_push_rdy;
    assign new_value  = fifo_vld;
    assign recvd_data = fifo_vld ? fifo_dat : '0;
`else
    // A clear in the same clk frees the holding register for the incoming word.
    assign store_ok   = rx_store & (~new_value | clear);
    assign store_drop = rx_store & new_value & ~clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            recvd_data <= '0;
            new_value  <= 1'b0;
        end else if (store_ok) begin
            recvd_data <= rx_shift;
            new_value  <= 1'b1;
        end else if (clear) begin
            new_value <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            parity_error  <= (parity_error  & ~clear) | (store_ok & rx_pe);
            framing_error <= (framing_error & ~clear) | (store_ok & rx_fe);
            overrun_error <= (overrun_error & ~clear) | store_drop;
        end
    end
endmodule

// File: tb/tb_uart_ext.sv
// Directed bench for uart_ext: 8N1 loopback pair A/B, even-parity receiver C, 7O2 pair D/E.
module tb_uart_ext;
    localparam int CF  = 5000000;
    localparam int BD  = 100000;
    localparam int BIT = 48;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       a_start = 1'b0, a_clear = 1'b0, a_tx, a_busy, a_nv, a_pe, a_fe, a_oe;
    logic [7:0] a_data = 8'h00, a_rd;
    logic       b_clear = 1'b0, b_inj = 1'b1, b_tx, b_busy, b_nv, b_pe, b_fe, b_oe;
    logic [7:0] b_rd;
    logic       c_clear = 1'b0, c_inj = 1'b1, c_tx, c_busy, c_nv, c_pe, c_fe, c_oe;
    logic [7:0] c_rd;
    logic       d_start = 1'b0, d_tx, d_busy, d_nv, d_pe, d_fe, d_oe;
    logic [6:0] d_data = 7'h00, d_rd;
    logic       e_clear = 1'b0, e_tx, e_busy, e_nv, e_pe, e_fe, e_oe;
    logic [6:0] e_rd;

    uart_ext #(.clock_frequency(CF), .baud_rate(BD)) ua (
        .clk(clk), .rst(rst), .rx(b_tx), .tx(a_tx), .start_transmit(a_start),
        .data_to_send(a_data), .busy(a_busy), .recvd_data(a_rd), .new_value(a_nv),
        .clear(a_clear), .parity_error(a_pe), .framing_error(a_fe), .overrun_error(a_oe));

    uart_ext #(.clock_frequency(CF), .baud_rate(BD)) ub (
        .clk(clk), .rst(rst), .rx(a_tx & b_inj), .tx(b_tx), .start_transmit(1'b0),
        .data_to_send(8'h00), .busy(b_busy), .recvd_data(b_rd), .new_value(b_nv),
        .clear(b_clear), .parity_error(b_pe), .framing_error(b_fe), .overrun_error(b_oe));

    uart_ext #(.clock_frequency(CF), .baud_rate(BD), .PARITY(2)) uc (
        .clk(clk), .rst(rst), .rx(c_inj), .tx(c_tx), .start_transmit(1'b0),
        .data_to_send(8'h00), .busy(c_busy), .recvd_data(c_rd), .new_value(c_nv),
        .clear(c_clear), .parity_error(c_pe), .framing_error(c_fe), .overrun_error(c_oe));

    uart_ext #(.clock_frequency(CF), .baud_rate(BD), .DATA_BITS(7), .STOP_BITS(2), .PARITY(1)) ud (
        .clk(clk), .rst(rst), .rx(e_tx), .tx(d_tx), .start_transmit(d_start),
        .data_to_send(d_data), .busy(d_busy), .recvd_data(d_rd), .new_value(d_nv),
        .clear(1'b0), .parity_error(d_pe), .framing_error(d_fe), .overrun_error(d_oe));

    uart_ext #(.clock_frequency(CF), .baud_rate(BD), .DATA_BITS(7), .STOP_BITS(2), .PARITY(1)) ue (
        .clk(clk), .rst(rst), .rx(d_tx), .tx(e_tx), .start_transmit(1'b0),
        .data_to_send(7'h00), .busy(e_busy), .recvd_data(e_rd), .new_value(e_nv),
        .clear(e_clear), .parity_error(e_pe), .framing_error(e_fe), .overrun_error(e_oe));

    // Serial frame onto B's or C's rx line, bit 0 first, one bit period per bit.
    task automatic inject(input int which, input logic [15:0] frame, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            if (which == 0) b_inj = frame[k]; else c_inj = frame[k];
            repeat (BIT) @(negedge clk);
        end
        b_inj = 1'b1;
        c_inj = 1'b1;
        repeat (BIT / 2) @(negedge clk);
    endtask

    task automatic pulse_clear(input int which);
        @(negedge clk);
        if (which == 0) b_clear = 1'b1; else if (which == 1) c_clear = 1'b1; else e_clear = 1'b1;
        @(negedge clk);
        b_clear = 1'b0;
        c_clear = 1'b0;
        e_clear = 1'b0;
    endtask

    task automatic wait_b_nv(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max && n < 0; i++) begin
            @(negedge clk);
            if (b_nv) n = i;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (a_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", a_tx); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        checks++; if (b_nv !== 1'b0) begin errors++; $display("FAIL reset_new_value: got %b want 0", b_nv); end
        checks++; if (b_rd !== 8'h00) begin errors++; $display("FAIL reset_recvd: got %h want 00", b_rd); end
        checks++; if ({b_pe, b_fe, b_oe} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {b_pe, b_fe, b_oe}); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_8n1;
        logic [9:0] frame;
        int busy_cnt, nv_at;
        logic busy_first;
        frame = '0; busy_cnt = 0; nv_at = -1; busy_first = 1'b0;
        a_data = 8'hAA;
        a_start = 1'b1;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (i == 1) begin a_start = 1'b0; busy_first = a_busy; end
            if (a_busy) busy_cnt++;
            if (i >= 24 && (i - 24) % BIT == 0 && (i - 24) / BIT < 10) frame[(i - 24) / BIT] = a_tx;
            if (b_nv && nv_at < 0) nv_at = i;
        end
        checks++; if (frame !== 10'b1_10101010_0) begin errors++; $display("FAIL 8n1_tx_frame: got %b want 1101010100", frame); end
        checks++; if (busy_first !== 1'b1) begin errors++; $display("FAIL 8n1_busy_latency: got %b want 1", busy_first); end
        checks++; if (busy_cnt != 10 * BIT) begin errors++; $display("FAIL 8n1_busy_len: got %0d want %0d", busy_cnt, 10 * BIT); end
        checks++; if (nv_at < 9 * BIT || nv_at > 10 * BIT) begin errors++; $display("FAIL 8n1_nv_time: got %0d want %0d..%0d", nv_at, 9 * BIT, 10 * BIT); end
        checks++; if (b_rd !== 8'hAA) begin errors++; $display("FAIL 8n1_data: got %h want aa", b_rd); end
        checks++; if ({b_pe, b_fe, b_oe} !== 3'b000) begin errors++; $display("FAIL 8n1_flags: got %b want 000", {b_pe, b_fe, b_oe}); end
        pulse_clear(0);
        checks++; if (b_nv !== 1'b0) begin errors++; $display("FAIL 8n1_clear: got %b want 0", b_nv); end
    endtask

    task automatic test_parity;
        inject(1, {5'b0, 1'b1, 1'b1, 8'h55, 1'b0}, 11);
        checks++; if (c_rd !== 8'h55) begin errors++; $display("FAIL par_bad_data: got %h want 55", c_rd); end
        checks++; if ({c_nv, c_pe, c_fe} !== 3'b110) begin errors++; $display("FAIL par_bad_flags: got %b want 110", {c_nv, c_pe, c_fe}); end
        pulse_clear(1);
        checks++; if ({c_nv, c_pe, c_fe, c_oe} !== 4'b0000) begin errors++; $display("FAIL par_clear: got %b want 0000", {c_nv, c_pe, c_fe, c_oe}); end
        inject(1, {5'b0, 1'b1, 1'b0, 8'h55, 1'b0}, 11);
        checks++; if ({c_nv, c_pe, c_rd} !== {2'b10, 8'h55}) begin errors++; $display("FAIL par_good: got %b/%b/%h want 1/0/55", c_nv, c_pe, c_rd); end
        pulse_clear(1);
    endtask

    task automatic test_framing;
        inject(0, {6'b0, 1'b0, 8'h3C, 1'b0}, 10);
        checks++; if (b_rd !== 8'h3C) begin errors++; $display("FAIL frm_data: got %h want 3c", b_rd); end
        checks++; if ({b_nv, b_fe, b_pe} !== 3'b110) begin errors++; $display("FAIL frm_flags: got %b want 110", {b_nv, b_fe, b_pe}); end
        repeat (BIT) @(negedge clk);
        pulse_clear(0);
        b_inj = 1'b0;
        repeat (14) @(negedge clk);
        b_inj = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        checks++; if ({b_nv, b_pe, b_fe, b_oe} !== 4'b0000) begin errors++; $display("FAIL glitch: got %b want 0000", {b_nv, b_pe, b_fe, b_oe}); end
    endtask

    task automatic test_overrun;
`ifdef UART_RX_FIFO_EN
        logic [7:0] w;
        for (int k = 1; k <= 5; k++) begin
            w = 8'(k * 17);
            inject(0, {6'b0, 1'b1, w, 1'b0}, 10);
        end
        checks++; if (b_oe !== 1'b1) begin errors++; $display("FAIL fifo_overrun: got %b want 1", b_oe); end
        for (int k = 1; k <= 4; k++) begin
            w = 8'(k * 17);
            checks++; if ({b_nv, b_rd} !== {1'b1, w}) begin errors++; $display("FAIL fifo_word%0d: got %b/%h want 1/%h", k, b_nv, b_rd, w); end
            pulse_clear(0);
        end
        checks++; if (b_nv !== 1'b0) begin errors++; $display("FAIL fifo_empty: got %b want 0", b_nv); end
`else
        inject(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10);
        inject(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10);
        checks++; if (b_rd !== 8'h11) begin errors++; $display("FAIL ovr_data: got %h want 11", b_rd); end
        checks++; if ({b_nv, b_oe, b_pe, b_fe} !== 4'b1100) begin errors++; $display("FAIL ovr_flags: got %b want 1100", {b_nv, b_oe, b_pe, b_fe}); end
        pulse_clear(0);
        checks++; if ({b_nv, b_oe} !== 2'b00) begin errors++; $display("FAIL ovr_clear: got %b want 00", {b_nv, b_oe}); end
`endif
    endtask

    task automatic test_reset_midframe;
        int n;
        a_data = 8'hC3;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (150) @(negedge clk);
        checks++; if ({a_tx, a_busy} !== 2'b01) begin errors++; $display("FAIL rmf_pre: got %b want 01", {a_tx, a_busy}); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({a_tx, a_busy} !== 2'b10) begin errors++; $display("FAIL rmf_tx_busy: got %b want 10", {a_tx, a_busy}); end
        checks++; if ({b_nv, b_rd, b_pe, b_fe, b_oe} !== 12'h0) begin errors++; $display("FAIL rmf_outputs: got %h want 000", {b_nv, b_rd, b_pe, b_fe, b_oe}); end
        rst = 1'b0;
        repeat (2 * BIT) @(negedge clk);
        a_data = 8'h96;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        wait_b_nv(700, n);
        checks++; if (n < 0 || b_rd !== 8'h96) begin errors++; $display("FAIL rmf_after: got %h (wait %0d) want 96", b_rd, n); end
        checks++; if ({b_pe, b_fe, b_oe} !== 3'b000) begin errors++; $display("FAIL rmf_after_flags: got %b want 000", {b_pe, b_fe, b_oe}); end
        pulse_clear(0);
        repeat (BIT) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int n;
        a_data = 8'h0F;
        a_start = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        a_data = 8'hF0;
        wait_b_nv(700, n);
        checks++; if (n < 0 || b_rd !== 8'h0F) begin errors++; $display("FAIL b2b_first: got %h (wait %0d) want 0f", b_rd, n); end
        pulse_clear(0);
        n = 0;
        while (a_busy && n < 600) begin @(negedge clk); n++; end
        @(negedge clk);
        checks++; if ({a_busy, a_tx} !== 2'b10) begin errors++; $display("FAIL b2b_restart: got %b want 10", {a_busy, a_tx}); end
        a_start = 1'b0;
        wait_b_nv(700, n);
        checks++; if (n < 0 || b_rd !== 8'hF0) begin errors++; $display("FAIL b2b_second: got %h (wait %0d) want f0", b_rd, n); end
        pulse_clear(0);
        repeat (BIT) @(negedge clk);
    endtask

    task automatic test_config;
        logic [10:0] frame;
        int busy_cnt;
        frame = '0; busy_cnt = 0;
        d_data = 7'h5A;
        d_start = 1'b1;
        for (int i = 1; i <= 700; i++) begin
            @(negedge clk);
            if (i == 1) d_start = 1'b0;
            if (d_busy) busy_cnt++;
            if (i >= 24 && (i - 24) % BIT == 0 && (i - 24) / BIT < 11) frame[(i - 24) / BIT] = d_tx;
        end
        checks++; if (frame !== {3'b111, 7'h5A, 1'b0}) begin errors++; $display("FAIL cfg_tx_frame: got %b want 11110110100", frame); end
        checks++; if (busy_cnt != 11 * BIT) begin errors++; $display("FAIL cfg_busy_len: got %0d want %0d", busy_cnt, 11 * BIT); end
        checks++; if ({e_nv, e_rd} !== {1'b1, 7'h5A}) begin errors++; $display("FAIL cfg_data: got %b/%h want 1/5a", e_nv, e_rd); end
        checks++; if ({e_pe, e_fe, e_oe} !== 3'b000) begin errors++; $display("FAIL cfg_flags: got %b want 000", {e_pe, e_fe, e_oe}); end
        pulse_clear(2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_framing();
        test_overrun();
        test_reset_midframe();
        test_back_to_back();
        test_config();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
